dense_frame_buffer: RTL

- Parametrised successor to the single-frame dense output latch at the PE array boundary.
- Captures the N_CH PE outputs of a dense layer into an open accumulation frame.
- The open frame is either overwritten or accumulated with saturation, so partial sums can be chunked across input passes.
- Committed frames queue in a DEPTH-frame FIFO and drain one channel per beat over a valid/ready stream. This replaces random rd_addr reads.

---
 rtl/dense_frame_buffer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/dense_frame_buffer.sv
// Dense-layer output frame buffer: accumulates PE outputs into an open frame,
// queues committed frames in a DEPTH-deep FIFO and streams them one channel per beat.
module dense_frame_buffer #(
    parameter int N_CH  = 8,
    parameter int WID   = 16,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_CH*WID-1:0]          data_in,
    input  logic                         latch,
    input  logic                         accum,
    input  logic                         commit,
    input  logic [$clog2(N_CH+1)-1:0]    frame_len,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WID-1:0]               out_data,
    output logic                         out_last,
    output logic [$clog2(DEPTH+1)-1:0]   frame_count,
    output logic                         full,
    output logic                         empty,
    output logic                         overflow,
    input  logic                         clear_ovf
);

    localparam int LW = $clog2(N_CH + 1);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                 state, state_nxt;
    logic signed [WID-1:0]  din [N_CH];
    logic signed [WID-1:0]  acc [N_CH];
    logic signed [WID-1:0]  mem [DEPTH][N_CH];
    logic [LW-1:0]          len_q [DEPTH];
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [IW-1:0]          ch_idx;
    logic [CW-1:0]          count_nxt;
    logic [LW-1:0]          len_fix, last_idx;
    logic                   pop, commit_ok;

    // Add at WID+1 bits; a sign mismatch between the two top bits means overflow.
    function automatic logic signed [WID-1:0] sat_add(input logic signed [WID-1:0] a,
                                                      input logic signed [WID-1:0] b);
        logic signed [WID:0] s;
        s = {a[WID-1], a} + {b[WID-1], b};
        if (s[WID] != s[WID-1])
            return s[WID] ? {1'b1, {(WID-1){1'b0}}} : {1'b0, {(WID-1){1'b1}}};
        return s[WID-1:0];
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < N_CH; i++)
            din[i] = data_in[i*WID +: WID];
    end

    assign out_valid = (state == STREAM);
    assign last_idx  = len_q[rd_ptr] - LW'(1);
    assign out_last  = out_valid && (LW'(ch_idx) == last_idx);
    assign out_data  = out_valid ? mem[rd_ptr][ch_idx] : '0;
    assign full      = (frame_count == CW'(DEPTH));
    assign empty     = (frame_count == '0);
    assign pop       = out_valid && out_ready && out_last;
    assign commit_ok = commit && (!full || pop);
    assign len_fix   = (frame_len == '0 || frame_len > LW'(N_CH)) ? LW'(N_CH) : frame_len;

    always_comb begin
        count_nxt = frame_count;
        if (commit_ok && !pop)
            count_nxt = frame_count + 1'b1;
        else if (pop && !commit_ok)
            count_nxt = frame_count - 1'b1;

        state_nxt = state;
        case (state)
            IDLE:    if (count_nxt != '0) state_nxt = STREAM;
            STREAM:  if (count_nxt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Open accumulation frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++)
                acc[i] <= '0;
        end else if (latch) begin
            for (int i = 0; i < N_CH; i++)
                acc[i] <= accum ? sat_add(acc[i], din[i]) : din[i];
        end
    end

    // Frame storage; contents are only meaningful behind the FIFO pointers
    always_ff @(posedge clk) begin
        if (commit_ok) begin
            for (int i = 0; i < N_CH; i++)
                mem[wr_ptr][i] <= acc[i];
            len_q[wr_ptr] <= len_fix;
        end
    end

    // FIFO control and read stream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            ch_idx      <= '0;
            frame_count <= '0;
            overflow    <= 1'b0;
        end else begin
            state       <= state_nxt;
            frame_count <= count_nxt;
            if (commit_ok)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop) begin
                ch_idx <= '0;
                rd_ptr <= ptr_inc(rd_ptr);
            end else if (out_valid && out_ready) begin
                ch_idx <= ch_idx + 1'b1;
            end
            if (commit && !commit_ok)
                overflow <= 1'b1;
            else if (clear_ovf)
                overflow <= 1'b0;
        end
    end

endmodule
